// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
//
// Two requesters compete to write one shared WIDTH-bit register. A request
// seen in IDLE is granted on that edge: Q captures the winner's data and the
// winner's GNT pulses for one cycle (GRANT). A lockout of HOLD_CYCLES cycles
// (HOLD) follows. Requests are ignored outside IDLE, so a requester simply
// keeps REQ high until it sees its GNT. Ties go round-robin against LAST.
//
// Parameters
//   WIDTH        data / register width
//   HOLD_CYCLES  lockout length after each grant, 0..15
//
// Ports
//   CLK          clock, rising edge active
//   RESET        asynchronous reset, active low
//   REQ0, D0     requester 0 write request and data
//   REQ1, D1     requester 1 write request and data
//   GNT0, GNT1   one-cycle registered grant pulses
//   Q            shared register contents
//   BUSY         high while not IDLE
//   LAST         index of the most recently granted requester (1 after reset)
// ----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] D0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D1,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             LAST
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StHold
    } state_e;

    localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES);

    state_e           state;
    logic [3:0]       cnt;

    logic             win_valid;
    logic             win_sel;
    logic [WIDTH-1:0] win_data;

    // Winner selection: a lone request always wins; on a tie the requester
    // that was not granted last time wins.
    always_comb begin
        win_valid = REQ0 | REQ1;
        if (REQ0 && REQ1) begin
            win_sel = ~LAST;
        end else begin
            win_sel = REQ1;
        end
        win_data = win_sel ? D1 : D0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= StIdle;
            cnt   <= 4'd0;
            Q     <= '0;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            LAST  <= 1'b1;
        end else begin
            // Grants are single-cycle pulses; only the IDLE branch raises one.
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
            case (state)
                StIdle: begin
                    if (win_valid) begin
                        Q     <= win_data;
                        LAST  <= win_sel;
                        GNT0  <= ~win_sel;
                        GNT1  <= win_sel;
                        state <= StGrant;
                    end
                end
                StGrant: begin
                    cnt   <= HoldLoad;
                    state <= (HoldLoad != 4'd0) ? StHold : StIdle;
                end
                StHold: begin
                    cnt <= cnt - 4'd1;
                    // Leaving on count 1 makes HOLD last exactly HoldLoad cycles.
                    if (cnt <= 4'd1) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign BUSY = (state != StIdle);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       req0_a, req1_a, req0_b, req1_b;
    logic [7:0] d0_a, d1_a, d0_b, d1_b;
    logic       gnt0_a, gnt1_a, busy_a, last_a;
    logic       gnt0_b, gnt1_b, busy_b, last_b;
    logic [7:0] q_a, q_b;

    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic [7:0]  q;
        logic        last;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default lockout of 2 cycles.
    reg_write_arbiter #(.WIDTH(8), .HOLD_CYCLES(2)) dut_a (
        .CLK(clk), .RESET(rst_n),
        .REQ0(req0_a), .D0(d0_a), .REQ1(req1_a), .D1(d1_a),
        .GNT0(gnt0_a), .GNT1(gnt1_a), .Q(q_a), .BUSY(busy_a), .LAST(last_a)
    );

    // Instance B: no lockout.
    reg_write_arbiter #(.WIDTH(8), .HOLD_CYCLES(0)) dut_b (
        .CLK(clk), .RESET(rst_n),
        .REQ0(req0_b), .D0(d0_b), .REQ1(req1_b), .D1(d1_b),
        .GNT0(gnt0_b), .GNT1(gnt1_b), .Q(q_b), .BUSY(busy_b), .LAST(last_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic g0, input logic g1, input logic [7:0] q,
                                input logic last, input int c);
        exp_t e;
        e.g0   = g0;
        e.g1   = g1;
        e.q    = q;
        e.last = last;
        e.cyc  = 32'(c);
        return e;
    endfunction

    // Monitors: every grant pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (gnt0_a || gnt1_a) begin
            exp_t got;
            got = mk(gnt0_a, gnt1_a, q_a, last_a, cyc);
            if (sb_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant_a: got %0h, expected no grant", got);
            end else begin
                check("grant_a", 64'(got), 64'(sb_a.pop_front()));
            end
        end
        if (gnt0_b || gnt1_b) begin
            exp_t got;
            got = mk(gnt0_b, gnt1_b, q_b, last_b, cyc);
            if (sb_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant_b: got %0h, expected no grant", got);
            end else begin
                check("grant_b", 64'(got), 64'(sb_b.pop_front()));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 20) begin
            tick();
            n++;
        end
        check("idle_a_timeout", 64'(busy_a), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        rst_n  = 1'b1;
        req0_a = 1'b0; req1_a = 1'b0; d0_a = 8'h00; d1_a = 8'h00;
        req0_b = 1'b0; req1_b = 1'b0; d0_b = 8'h00; d1_b = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        check("rst_q_a",    64'(q_a),    64'h0);
        check("rst_gnt0_a", 64'(gnt0_a), 64'h0);
        check("rst_gnt1_a", 64'(gnt1_a), 64'h0);
        check("rst_busy_a", 64'(busy_a), 64'h0);
        check("rst_last_a", 64'(last_a), 64'h1);
        check("rst_q_b",    64'(q_b),    64'h0);
        check("rst_last_b", 64'(last_b), 64'h1);

        // Release reset with REQ1 already high: first edge grants requester 1.
        req1_a = 1'b1;
        d1_a   = 8'h3C;
        repeat (2) tick();
        rst_n = 1'b1;
        sb_a.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b1, cyc + 1));
        tick();
        req1_a = 1'b0;
        check("first_gnt0_low", 64'(gnt0_a), 64'h0);
        check("first_q", 64'(q_a), 64'h3C);
        wait_idle_a();

        // Single request; BUSY spans GRANT plus two HOLD cycles.
        req0_a = 1'b1;
        d0_a   = 8'hA5;
        sb_a.push_back(mk(1'b1, 1'b0, 8'hA5, 1'b0, cyc + 1));
        tick();
        req0_a = 1'b0;
        n = 0;
        while (busy_a && n < 10) begin
            n++;
            tick();
        end
        check("busy_len_a", 64'(n), 64'd3);
        check("single_last", 64'(last_a), 64'h0);
        check("single_q_held", 64'(q_a), 64'hA5);

        // Asynchronous reset in the middle of HOLD.
        req0_a = 1'b1;
        d0_a   = 8'h5A;
        sb_a.push_back(mk(1'b1, 1'b0, 8'h5A, 1'b0, cyc + 1));
        tick();
        req0_a = 1'b0;
        tick();
        check("in_hold_busy", 64'(busy_a), 64'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_q",    64'(q_a),    64'h0);
        check("midrst_gnt0", 64'(gnt0_a), 64'h0);
        check("midrst_gnt1", 64'(gnt1_a), 64'h0);
        check("midrst_busy", 64'(busy_a), 64'h0);
        check("midrst_last", 64'(last_a), 64'h1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 64'(busy_a), 64'h0);

        // Tie held continuously: round-robin every 4 edges, requester 0 first.
        c0     = cyc;
        req0_a = 1'b1; d0_a = 8'h11;
        req1_a = 1'b1; d1_a = 8'h22;
        sb_a.push_back(mk(1'b1, 1'b0, 8'h11, 1'b0, c0 + 1));
        sb_a.push_back(mk(1'b0, 1'b1, 8'h22, 1'b1, c0 + 5));
        sb_a.push_back(mk(1'b1, 1'b0, 8'h11, 1'b0, c0 + 9));
        sb_a.push_back(mk(1'b0, 1'b1, 8'h22, 1'b1, c0 + 13));
        while (cyc < c0 + 13) tick();
        req0_a = 1'b0;
        req1_a = 1'b0;
        wait_idle_a();

        // Request raised during HOLD waits for the first IDLE edge.
        c0     = cyc;
        req0_a = 1'b1;
        d0_a   = 8'h77;
        sb_a.push_back(mk(1'b1, 1'b0, 8'h77, 1'b0, c0 + 1));
        tick();
        req0_a = 1'b0;
        tick();
        req1_a = 1'b1;
        d1_a   = 8'h99;
        sb_a.push_back(mk(1'b0, 1'b1, 8'h99, 1'b1, c0 + 5));
        tick();
        check("late_gnt1_hold", 64'(gnt1_a), 64'h0);
        check("late_q_held", 64'(q_a), 64'h77);
        tick();
        check("late_gnt1_idle", 64'(gnt1_a), 64'h0);
        tick();
        check("late_gnt1_grant", 64'(gnt1_a), 64'h1);
        check("late_q", 64'(q_a), 64'h99);
        req1_a = 1'b0;
        wait_idle_a();

        // No lockout: REQ1 held gives a grant every 2 cycles, BUSY toggles.
        c0     = cyc;
        req1_b = 1'b1;
        d1_b   = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            sb_b.push_back(mk(1'b0, 1'b1, 8'hC3, 1'b1, c0 + 1 + 2 * k));
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("busy_toggle_b", 64'(busy_b), 64'(i % 2));
            if (i == 7) req1_b = 1'b0;
        end

        repeat (3) tick();
        check("sb_a_empty", 64'(sb_a.size()), 64'd0);
        check("sb_b_empty", 64'(sb_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
